dmem_bytelane: RTL and testbench

Parametrised byte-lane data memory for the RV32I datapath. It replaces the plain word-addressed RAM and adds several features: full load/store width handling from funct3 (B/H/W, signed/unsigned), a registered one-cycle read, a valid/ready request with a response pulse, misalignment and range error reporting, and a post-reset hardware initialisation sweep. It sits between the execute stage's ALU address/rs2 outputs and the writeback mux.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_align.sv | 71 +++++++
 rtl/dmem_bytelane.sv | 108 ++++++++++
 tb/tb_dmem_bytelane.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the byte-lane data memory: RV32I load/store widths and
// the controller state encoding.
package dmem_pkg;

   typedef enum logic [2:0] {
      LS_B  = 3'b000,
      LS_H  = 3'b001,
      LS_W  = 3'b010,
      LS_BU = 3'b100,
      LS_HU = 3'b101
   } ls_funct3_e;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } dmem_state_e;

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: store byte enables and replication, load extract
// and extension, and misalignment / illegal-funct3 detection.
module dmem_align
   import dmem_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata,
   output logic        err
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rword[{offset, 3'b000} +: 8];
   assign half_sel = rword[{offset[1], 4'b0000} +: 16];

   always_comb begin
      be        = 4'b0000;
      wdata_rep = wdata;
      rdata     = 32'h0;
      err       = 1'b0;
      if (we) begin
         case (funct3)
            LS_B: begin
               be        = 4'b0001 << offset;
               wdata_rep = {4{wdata[7:0]}};
            end
            LS_H: begin
               err       = offset[0];
               be        = offset[1] ? 4'b1100 : 4'b0011;
               wdata_rep = {2{wdata[15:0]}};
            end
            LS_W: begin
               err = |offset;
               be  = 4'b1111;
            end
            default: err = 1'b1;
         endcase
      end else begin
         case (funct3)
            LS_B:  rdata = {{24{byte_sel[7]}}, byte_sel};
            LS_BU: rdata = {24'h0, byte_sel};
            LS_H: begin
               err   = offset[0];
               rdata = {{16{half_sel[15]}}, half_sel};
            end
            LS_HU: begin
               err   = offset[0];
               rdata = {16'h0, half_sel};
            end
            LS_W: begin
               err   = |offset;
               rdata = rword;
            end
            default: err = 1'b1;
         endcase
      end
      // A rejected request must never touch memory or return data.
      if (err) begin
         be    = 4'b0000;
         rdata = 32'h0;
      end
   end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory with post-reset init sweep, one-cycle registered
// response and range/alignment error reporting.
//
// state   | meaning
// ST_INIT | sweeping ram[i] = INIT_BASE + i, requests ignored
// ST_RUN  | accepting one request per cycle
module dmem_bytelane
   import dmem_pkg::*;
#(
   parameter int DEPTH     = 64,
   parameter int INIT_BASE = 100
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        init_done
);

   localparam int AW = $clog2(DEPTH);

   dmem_state_e state, state_next;
   logic [AW-1:0] init_cnt;
   logic [31:0]   ram [DEPTH];

   logic [AW-1:0] idx;
   logic          range_err;
   logic          align_err;
   logic          err;
   logic          accept;
   logic [3:0]    be;
   logic [31:0]   wdata_rep;
   logic [31:0]   load_data;

   assign idx       = req_addr[AW+1:2];
   assign range_err = |req_addr[31:AW+2];
   assign err       = range_err | align_err;
   assign accept    = req_valid & req_ready;

   dmem_align u_align (
      .we        (req_we),
      .funct3    (req_funct3),
      .offset    (req_addr[1:0]),
      .wdata     (req_wdata),
      .rword     (ram[idx]),
      .be        (be),
      .wdata_rep (wdata_rep),
      .rdata     (load_data),
      .err       (align_err)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) state <= ST_INIT;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      init_done  = 1'b0;
      case (state)
         ST_INIT: if (init_cnt == AW'(DEPTH - 1)) state_next = ST_RUN;
         ST_RUN: begin
            req_ready = 1'b1;
            init_done = 1'b1;
         end
         default: state_next = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n)              init_cnt <= '0;
      else if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
   end

   // RAM has no reset of its own; the sweep defines its contents.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         if (state == ST_INIT) begin
            ram[init_cnt] <= 32'(INIT_BASE) + {{(32-AW){1'b0}}, init_cnt};
         end else if (accept && req_we && !err) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) ram[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 32'h0;
      end else begin
         rsp_valid <= accept;
         rsp_err   <= accept & err;
         if (accept) rsp_rdata <= (err || req_we) ? 32'h0 : load_data;
      end
   end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed plus randomized bench for dmem_bytelane against a word-array
// reference model computed from access size, offset and extension rules.
module tb_dmem_bytelane;

   localparam int DEPTH     = 64;
   localparam int INIT_BASE = 100;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        init_done;

   int checks   = 0;
   int failures = 0;
   logic [31:0] mem [DEPTH];

   dmem_bytelane #(.DEPTH(DEPTH), .INIT_BASE(INIT_BASE)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .init_done  (init_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s at %0t: observed=0x%08h expected=0x%08h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_init();
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'(INIT_BASE + i);
   endtask

   // Reference: size from funct3, legality, alignment, range, then bytewise access.
   task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, output logic e, output logic [31:0] r);
      int unsigned size, off, w, lane;
      logic legal;
      longint unsigned word_idx;
      logic [31:0] v, mask;
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                 : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      off      = addr % 4;
      word_idx = longint'(addr) / 4;
      e = !legal || (addr % size != 0) || (word_idx >= DEPTH);
      r = 32'h0;
      if (e) return;
      w = int'(word_idx);
      if (we) begin
         for (int b = 0; b < int'(size); b++) begin
            lane   = off + b;
            mem[w] = (mem[w] & ~(32'hFF << (8*lane))) | (((wd >> (8*b)) & 32'hFF) << (8*lane));
         end
      end else begin
         v = mem[w] >> (8*off);
         if (size < 4) begin
            mask = (32'h1 << (8*size)) - 1;
            v = v & mask;
            if (!f3[2] && v[8*size-1]) v = v | ~mask;
         end
         r = v;
      end
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
      logic e;
      logic [31:0] r;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      ref_access(we, f3, addr, wd, e, r);
      @(posedge clk); #1;
      chk("rsp_valid", {31'h0, rsp_valid}, 32'd1);
      chk("rsp_err",   {31'h0, rsp_err},   {31'h0, e});
      chk("rsp_rdata", rsp_rdata, r);
   endtask

   task automatic idle();
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("idle_rsp_valid", {31'h0, rsp_valid}, 32'd0);
   endtask

   task automatic wait_init();
      for (int i = 1; i <= DEPTH; i++) begin
         @(posedge clk); #1;
         chk("init_ready", {31'h0, req_ready}, (i == DEPTH) ? 32'd1 : 32'd0);
         chk("init_done",  {31'h0, init_done}, (i == DEPTH) ? 32'd1 : 32'd0);
         chk("init_no_rsp", {31'h0, rsp_valid}, 32'd0);
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd2;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      model_init();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      chk("rst_rsp_err",   {31'h0, rsp_err},   32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_ready",     {31'h0, req_ready}, 32'd0);
      chk("rst_init_done", {31'h0, init_done}, 32'd0);

      // Requests held during the sweep must be ignored.
      reset_n   = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h8;
      wait_init();

      issue(0, 3'b010, 32'h08, 0);           chk("lw08", rsp_rdata, 32'd102);
      issue(1, 3'b010, 32'h10, 32'hDEADBEEF);
      issue(0, 3'b000, 32'h13, 0);           chk("lb13", rsp_rdata, 32'hFFFFFFDE);
      issue(0, 3'b100, 32'h13, 0);           chk("lbu13", rsp_rdata, 32'h000000DE);
      issue(0, 3'b001, 32'h12, 0);           chk("lh12", rsp_rdata, 32'hFFFFDEAD);
      issue(0, 3'b101, 32'h10, 0);           chk("lhu10", rsp_rdata, 32'h0000BEEF);
      idle();
      issue(1, 3'b000, 32'h21, 32'h0000007F);
      issue(0, 3'b010, 32'h20, 0);           chk("sb_lw20", rsp_rdata, 32'h00007F6C);
      issue(1, 3'b001, 32'h22, 32'h00001234);
      issue(0, 3'b010, 32'h20, 0);           chk("sh_lw20", rsp_rdata, 32'h12347F6C);
      issue(0, 3'b010, 32'h22, 0);           chk("lw22_err", {31'h0, rsp_err}, 32'd1);
      issue(1, 3'b001, 32'h05, 32'hFFFF);    chk("sh05_err", {31'h0, rsp_err}, 32'd1);
      issue(0, 3'b010, 32'h04, 0);           chk("lw04", rsp_rdata, 32'd101);
      issue(0, 3'b011, 32'h04, 0);           chk("f3_011_err", {31'h0, rsp_err}, 32'd1);
      issue(0, 3'b010, 32'h100, 0);          chk("lw100_err", {31'h0, rsp_err}, 32'd1);
      issue(1, 3'b010, 32'h100, 32'h55);     chk("sw100_err", {31'h0, rsp_err}, 32'd1);
      issue(0, 3'b010, 32'h00, 0);           chk("lw00_nowrap", rsp_rdata, 32'd100);
      issue(1, 3'b010, 32'h30, 32'hA5A5A5A5);
      issue(0, 3'b010, 32'h30, 0);           chk("raw30", rsp_rdata, 32'hA5A5A5A5);
      idle();

      for (int n = 0; n < 400; n++) begin
         issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               32'($urandom_range(0, 4*DEPTH + 31)), $urandom);
         if ($urandom_range(0, 7) == 0) idle();
      end

      // Reset mid-stream drops the in-flight response and blocks acceptance.
      issue(0, 3'b010, 32'h30, 0);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h30;
      req_wdata  = 32'h12345678;
      reset_n    = 1'b0;
      @(posedge clk); #1;
      chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      chk("midrst_ready",     {31'h0, req_ready}, 32'd0);
      chk("midrst_rdata",     rsp_rdata, 32'd0);
      reset_n   = 1'b1;
      req_valid = 1'b0;
      model_init();
      wait_init();
      issue(0, 3'b010, 32'h30, 0);           chk("reinit_lw30", rsp_rdata, 32'd112);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
